imem_loader: RTL

Sequential program-image loader driving port 2 (the loader/write side) of the instruction-memory arbiter in the ProGe testbench. Accepts a stream of instruction words on a valid/ready interface and writes them to consecutive imem addresses starting at a programmable base. Honours the arbiter's mem_busy back-pressure by retrying stalled writes. Reports busy/done to the bench so the core can be released after load.

---
 rtl/imem_loader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams program words into instruction memory through port 2
// of the imem arbiter. Each accepted stream word becomes one write. A write
// that loses the arbiter (mem_busy=1) is presented again on the following
// cycles until it commits.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start               one-cycle pulse that begins a load (only in IDLE)
//   base_addr           first write address, sampled with start
//   word_count          number of words to write, sampled with start
//   s_data/s_valid      stream word input
//   s_ready             registered; high for the whole of WAIT_DATA
//   addr_2, d_2         arbiter port-2 address and write data
//   en_2_x, wr_2_x      arbiter port-2 active-low enable and write
//   bit_wr_2_x          arbiter port-2 active-low bit-write mask
//   mem_busy            arbiter grants port 1 this cycle; port-2 access dropped
//   busy, done          load in progress / one-cycle completion pulse
//   checksum            running sum of committed words
//
// Build option: define IMEM_LOADER_CHECKSUM_EN to build the checksum adder.
// Without it, checksum is tied to zero.

module imem_loader #(
  parameter int unsigned PORTW     = 32,
  parameter int unsigned ADDRWIDTH = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDRWIDTH-1:0] base_addr,
  input  logic [ADDRWIDTH:0]   word_count,
  input  logic [PORTW-1:0]     s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [ADDRWIDTH-1:0] addr_2,
  output logic [PORTW-1:0]     d_2,
  output logic                 en_2_x,
  output logic                 wr_2_x,
  output logic [PORTW-1:0]     bit_wr_2_x,
  input  logic                 mem_busy,
  output logic                 busy,
  output logic                 done,
  output logic [PORTW-1:0]     checksum
);

  localparam int unsigned CNTW = ADDRWIDTH + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    WRITE     = 2'd2,
    DONE      = 2'd3
  } state_e;

  state_e               state_q;
  logic [ADDRWIDTH-1:0] addr_cnt_q, addr_cnt_d;
  logic [CNTW-1:0]      rem_q, rem_d;
  logic                 s_ready_q;
  logic [ADDRWIDTH-1:0] addr_2_q;
  logic [PORTW-1:0]     d_2_q;
  logic                 en_2_x_q;
  logic                 wr_2_x_q;
  logic [PORTW-1:0]     bit_wr_2_x_q;
  logic                 busy_q;
  logic                 done_q;

  // Address wraps modulo 2^ADDRWIDTH.
  always_comb begin
    addr_cnt_d = addr_cnt_q + ADDRWIDTH'(1);
    rem_d      = rem_q - CNTW'(1);
  end

  // Load sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_cnt_q   <= '0;
      rem_q        <= '0;
      s_ready_q    <= 1'b0;
      addr_2_q     <= '0;
      d_2_q        <= '0;
      en_2_x_q     <= 1'b1;
      wr_2_x_q     <= 1'b1;
      bit_wr_2_x_q <= '1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            addr_cnt_q <= base_addr;
            rem_q      <= word_count;
            busy_q     <= 1'b1;
            if (word_count == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= WAIT_DATA;
              s_ready_q <= 1'b1;
            end
          end
        end
        WAIT_DATA: begin
          // s_ready_q is high throughout this state, so s_valid alone is the handshake.
          if (s_valid) begin
            d_2_q        <= s_data;
            addr_2_q     <= addr_cnt_q;
            s_ready_q    <= 1'b0;
            en_2_x_q     <= 1'b0;
            wr_2_x_q     <= 1'b0;
            bit_wr_2_x_q <= '0;
            state_q      <= WRITE;
          end
        end
        WRITE: begin
          // While mem_busy is high, every output is held and the write is presented again.
          if (!mem_busy) begin
            addr_cnt_q   <= addr_cnt_d;
            rem_q        <= rem_d;
            en_2_x_q     <= 1'b1;
            wr_2_x_q     <= 1'b1;
            bit_wr_2_x_q <= '1;
            if (rem_q == CNTW'(1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= WAIT_DATA;
              s_ready_q <= 1'b1;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [PORTW-1:0] sum_q;

  // Sums committed writes only. Retried cycles do not add to the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else if (state_q == IDLE && start) begin
      sum_q <= '0;
    end else if (state_q == WRITE && !mem_busy) begin
      sum_q <= sum_q + d_2_q;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

  assign s_ready    = s_ready_q;
  assign addr_2     = addr_2_q;
  assign d_2        = d_2_q;
  assign en_2_x     = en_2_x_q;
  assign wr_2_x     = wr_2_x_q;
  assign bit_wr_2_x = bit_wr_2_x_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
